// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial (slice-at-a-time) arithmetic blocks.
// Holds the controller state encoding and the step-counter width helper.
package serial_arith_pkg;

    // Controller states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    // Width of a counter that must hold the values 0 .. steps-1.
    // A single-step configuration still needs a 1-bit counter.
    function automatic int step_cnt_w(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage : serial_arith_pkg

// File: rtl/adder_slice.sv
// Combinational N-bit ripple adder built from chained full-adder equations.
// Besides the sum and carry-out it exposes the carry into its MSB, which the
// parent uses to derive two's-complement overflow on the last slice.
module adder_slice #(
    parameter int N = 1
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         c_msb_o
);

    // Internal carry chain: c[i] is the carry into bit i, c[N] the carry out.
    logic [N:0] c;

    // Ripple the carry through N full adders, LSB first.
    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = c_i;
        for (int i = 0; i < N; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o  = c[N];
    assign c_msb_o = c[N-1];

endmodule : adder_slice

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands BITS_PER_CYCLE
// bits at a time, LSB first, with a registered carry between slices.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a signed-overflow output.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready is high only in IDLE (and low
// while rst_n is low); out_valid is high only in DONE, and sum/cout (and ovf)
// stay stable from the first out_valid cycle until the transfer completes.
// in_valid/out_ready are ignored in states that do not use them.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               cout,
    output logic               busy,
`ifdef SERIAL_ADDER_OVF_EN
    output logic               ovf,
`endif
    output serial_state_t      dbg_state
);

    localparam int STEPS  = WIDTH / BITS_PER_CYCLE;
    localparam int STEP_W = step_cnt_w(STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    // Reject configurations where the slices do not tile the operand exactly.
    if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("serial_adder: BITS_PER_CYCLE (%0d) must divide WIDTH (%0d), both >= 1",
               BITS_PER_CYCLE, WIDTH);
    end

    // Controller state.
    serial_state_t state_q, state_d;

    // Operand shifters: the low slice of each is consumed every RUN cycle.
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    // Carry chained between slices.
    logic              carry_q, carry_d;
    // Index of the slice being processed.
    logic [STEP_W-1:0] step_q, step_d;
    // Partial result, filled from the MSB end as slices complete.
    logic [WIDTH-1:0]  res_sh_q, res_sh_d;
    // Visible result, updated only when the last slice completes.
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // Slice adder signals.
    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic                      slice_cout;
    logic                      slice_c_msb;
    logic [WIDTH-1:0]          slice_ext;
    logic [WIDTH-1:0]          res_next;
    logic                      accept;

    adder_slice #(
        .N (BITS_PER_CYCLE)
    ) u_slice (
        .a_i     (a_sh_q[BITS_PER_CYCLE-1:0]),
        .b_i     (b_sh_q[BITS_PER_CYCLE-1:0]),
        .c_i     (carry_q),
        .sum_o   (slice_sum),
        .cout_o  (slice_cout),
        .c_msb_o (slice_c_msb)
    );

`ifndef SERIAL_ADDER_OVF_EN
    // The MSB carry only matters for overflow detection.
    logic unused_c_msb;
    assign unused_c_msb = slice_c_msb;
`endif

    // The new slice enters at the top; earlier slices move down one slot.
    // After STEPS shifts the first slice has reached bit 0.
    assign slice_ext = WIDTH'(slice_sum);
    assign res_next  = (res_sh_q >> BITS_PER_CYCLE) | (slice_ext << (WIDTH - BITS_PER_CYCLE));

    // in_ready is forced low while reset is asserted even though state is IDLE.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

    // State register with asynchronous abort to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)               state_d = RUN;
            RUN:  if (step_q == LAST_STEP)  state_d = DONE;
            DONE: if (out_ready)            state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift/add in RUN, publish at the end.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        carry_d  = carry_q;
        step_d   = step_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Subtraction is a + ~b + 1; cin is ignored in that mode.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    step_d  = '0;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> BITS_PER_CYCLE;
                b_sh_d   = b_sh_q >> BITS_PER_CYCLE;
                carry_d  = slice_cout;
                step_d   = step_q + STEP_W'(1);
                res_sh_d = res_next;
                if (step_q == LAST_STEP) begin
                    step_d = '0;
                    sum_d  = res_next;
                    cout_d = slice_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // Signed overflow: carry into MSB differs from carry out.
                    ovf_d  = slice_c_msb ^ slice_cout;
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything so an aborted run leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            carry_q  <= 1'b0;
            step_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            carry_q  <= carry_d;
            step_q   <= step_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. Three instances cover WIDTH/BITS_PER_CYCLE
// of 8/1, 16/4 and 8/8. Expected results come from a plain-arithmetic model and
// are queued at issue time; a monitor pops and compares when out_valid rises.
// Honours SERIAL_ADDER_OVF_EN when defined.
module tb_serial_adder;
  import serial_arith_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  co;
  logic [2:0]  bz;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic        cin_bus;
  logic        sub_bus;
  logic        out_ready;
  logic [7:0]  s0;
  logic [15:0] s1;
  logic [7:0]  s2;
  logic [15:0] sum_w [3];
  serial_state_t st0, st1, st2;
`ifdef SERIAL_ADDER_OVF_EN
  logic [2:0]  of_w;
`endif

  always_comb begin
    sum_w[0] = {8'h00, s0};
    sum_w[1] = s1;
    sum_w[2] = {8'h00, s2};
  end

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin_bus), .sub(sub_bus),
    .out_valid(ov[0]), .out_ready(out_ready), .sum(s0), .cout(co[0]), .busy(bz[0]),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(of_w[0]),
`endif
    .dbg_state(st0)
  );

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_bus), .b(b_bus), .cin(cin_bus), .sub(sub_bus),
    .out_valid(ov[1]), .out_ready(out_ready), .sum(s1), .cout(co[1]), .busy(bz[1]),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(of_w[1]),
`endif
    .dbg_state(st1)
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin_bus), .sub(sub_bus),
    .out_valid(ov[2]), .out_ready(out_ready), .sum(s2), .cout(co[2]), .busy(bz[2]),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(of_w[2]),
`endif
    .dbg_state(st2)
  );

  // ---------------- scoreboard state ----------------
  // Entry layout: {dut_id[1:0], ovf, cout, sum[15:0]}
  logic [19:0] exp_q[$];
  int          acc_q[$];
  logic [19:0] cur_exp [3];
  logic [2:0]  seen;
  int          errors;
  int          checks;
  int          rdy_mode;   // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 1) ? 16 : 8;
  endfunction

  function automatic int steps_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
  endfunction

  // Reference model: plain unsigned/signed integer arithmetic.
  function automatic logic [19:0] model(input int k, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin,
                                        input logic sub);
    longint md, ua, ub, sa, sb, r, sr;
    logic   c, o;
    logic [1:0] tag;
    md = longint'(1) << width_of(k);
    ua = longint'(a) % md;
    ub = longint'(b) % md;
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    if (sub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + longint'(cin);
      c  = (r >= md);
      sr = sa + sb + longint'(cin);
    end
    o = (sr >= md / 2) || (sr < -(md / 2));
    r = ((r % md) + md) % md;
    tag = k[1:0];
    return {tag, o, c, r[15:0]};
  endfunction

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k]) begin
          if (!seen[k]) begin
            seen[k] = 1'b1;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
              check("unexpected_output", {30'd0, k[1:0]}, 32'hFFFF_FFFF);
              cur_exp[k] = {k[1:0], 1'b0, co[k], sum_w[k]};
            end else begin
              cur_exp[k] = exp_q.pop_front();
              check("dut_order", {30'd0, k[1:0]}, {30'd0, cur_exp[k][19:18]});
              check("sum", {16'd0, sum_w[k]}, {16'd0, cur_exp[k][15:0]});
              check("cout", {31'd0, co[k]}, {31'd0, cur_exp[k][16]});
`ifdef SERIAL_ADDER_OVF_EN
              check("ovf", {31'd0, of_w[k]}, {31'd0, cur_exp[k][17]});
`endif
              check("latency", cyc - acc_q.pop_front(), steps_of(k));
            end
          end else begin
            check("hold_sum", {16'd0, sum_w[k]}, {16'd0, cur_exp[k][15:0]});
            check("hold_cout", {31'd0, co[k]}, {31'd0, cur_exp[k][16]});
          end
          check("in_ready_low_in_done", {31'd0, ir[k]}, 32'd0);
          check("busy_in_done", {31'd0, bz[k]}, 32'd1);
        end else begin
          seen[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    int g;
    g = 0;
    @(negedge clk);
    while (!ir[k] && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!ir[k]) begin
      check("accept_timeout", {31'd0, ir[k]}, 32'd1);
      return;
    end
    a_bus   = a;
    b_bus   = b;
    cin_bus = c;
    sub_bus = s;
    iv[k]   = 1'b1;
    exp_q.push_back(model(k, a, b, c, s));
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    iv = '0;
    // Scramble operands: they must be ignored after the accept edge.
    a_bus   = 16'($urandom);
    b_bus   = 16'($urandom);
    cin_bus = 1'($urandom_range(0, 1));
    sub_bus = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
    end
    g = 0;
    while (ir != 3'b111 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (ir != 3'b111) check("idle_timeout", {29'd0, ir}, 32'd7);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int g;
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    rdy_mode = 0;
    seen     = '0;
    iv       = '0;
    a_bus    = '0;
    b_bus    = '0;
    cin_bus  = 1'b0;
    sub_bus  = 1'b0;
    rst_n    = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_in_ready", {29'd0, ir}, 32'd0);
    check("rst_out_valid", {29'd0, ov}, 32'd0);
    check("rst_busy", {29'd0, bz}, 32'd0);
    check("rst_cout", {29'd0, co}, 32'd0);
    check("rst_sum0", {24'd0, s0}, 32'd0);
    check("rst_sum1", {16'd0, s1}, 32'd0);
    check("rst_state", {30'd0, st0}, {30'd0, IDLE});
    rst_n = 1'b1;
    #1;
    check("in_ready_after_release", {29'd0, ir}, 32'd7);

    // Directed: basic add, wrap-around, subtract with cin ignored, overflow cases.
    do_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0);
    do_op(0, 16'hFF, 16'h01, 1'b1, 1'b0);
    do_op(0, 16'h10, 16'h20, 1'b1, 1'b1);
    do_op(0, 16'h7F, 16'h01, 1'b0, 1'b0);
    do_op(0, 16'h80, 16'h01, 1'b0, 1'b1);
    do_op(0, 16'h05, 16'h03, 1'b0, 1'b0);
    drain();

    // Backpressure: hold out_ready low, try to sneak in another operation.
    rdy_mode = 2;
    do_op(0, 16'h33, 16'h44, 1'b1, 1'b0);
    g = 0;
    while (!ov[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("bp_out_valid_seen", {31'd0, ov[0]}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv[0] = (i == 2);
      a_bus = 16'h0011;
      b_bus = 16'h0022;
      check("bp_still_valid", {31'd0, ov[0]}, 32'd1);
      check("bp_state_done", {30'd0, st0}, {30'd0, DONE});
    end
    @(negedge clk);
    iv = '0;
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", {31'd0, ov[0]}, 32'd0);
    check("bp_release_in_ready", {31'd0, ir[0]}, 32'd1);
    check("bp_release_busy", {31'd0, bz[0]}, 32'd0);
    repeat (12) @(negedge clk);
    check("bp_no_ghost_op", {31'd0, ov[0]}, 32'd0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a run.
    do_op(0, 16'hAA, 16'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, ov[0]}, 32'd0);
    check("abort_busy", {31'd0, bz[0]}, 32'd0);
    check("abort_sum", {24'd0, s0}, 32'd0);
    check("abort_cout", {31'd0, co[0]}, 32'd0);
    check("abort_in_ready", {31'd0, ir[0]}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 16'h01, 16'h01, 1'b0, 1'b0);
    drain();

    // Other configurations.
    do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain();
    do_op(2, 16'h5A, 16'h3C, 1'b0, 1'b0);
    do_op(2, 16'hFF, 16'h01, 1'b1, 1'b0);
    drain();

    // Randomized traffic with random backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      do_op(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
    end
    drain();
    for (int n = 0; n < 100; n++) begin
      do_op(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
    end
    drain();
    for (int n = 0; n < 100; n++) begin
      do_op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
    end
    drain();

    // Final report.
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_adder
